// File: rtl/mult_share_ctrl.sv
// Two-way round-robin arbiter and sequencer for the shift-add multiplier datapath.
// Grants one requester, drives init/plus/shift/finish with early termination and returns the tagged product.
module mult_share_ctrl #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           req0,
    input  logic           req1,
    input  logic [N-1:0]   a0,
    input  logic [N-1:0]   b0,
    input  logic [N-1:0]   a1,
    input  logic [N-1:0]   b1,
    output logic           gnt0,
    output logic           gnt1,
    output logic [N-1:0]   dp_a_in,
    output logic [N-1:0]   dp_b_in,
    output logic           init,
    output logic           plus,
    output logic           shift,
    output logic           finish,
    input  logic [N-1:0]   dp_b,
    input  logic [2*N-1:0] dp_s,
    output logic [2*N-1:0] res,
    output logic           res_id,
    output logic           res_valid,
    output logic           busy
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    op_a_q, op_b_q;
    logic            cur_id_q, last_id_q;
    logic [CW-1:0]   cnt_q;
    logic            gnt0_q, gnt1_q;
    logic [2*N-1:0]  res_q;
    logic            res_id_q, res_valid_q;

    logic            grant_s, win_s, done_s, step_s;

    // Arbitration: a tie goes to the requester that was not served last.
    always_comb begin
        grant_s = (state_q == S_IDLE) && (req0 || req1);
        if (req0 && req1) begin
            win_s = ~last_id_q;
        end else begin
            win_s = req1;
        end
        done_s = (state_q == S_RUN) && ((dp_b == '0) || (cnt_q == CNT_MAX));
        step_s = (state_q == S_RUN) && !done_s;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = grant_s ? S_INIT : S_IDLE;
            S_INIT:  state_d = S_RUN;
            S_RUN:   state_d = done_s ? S_IDLE : S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath controls are decoded from state; dp_b[0] picks add-and-shift versus shift.
    always_comb begin
        init   = 1'b0;
        plus   = 1'b0;
        shift  = 1'b0;
        finish = 1'b0;
        case (state_q)
            S_INIT: init = 1'b1;
            S_RUN: begin
                plus   = step_s & dp_b[0];
                shift  = step_s & ~dp_b[0];
                finish = done_s;
            end
            default: begin
                init = 1'b0;
            end
        endcase
    end

    // Operand capture, grant pulses, step counter and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a_q      <= '0;
            op_b_q      <= '0;
            cur_id_q    <= 1'b0;
            last_id_q   <= 1'b1;
            cnt_q       <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            res_q       <= '0;
            res_id_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            gnt0_q      <= grant_s & ~win_s;
            gnt1_q      <= grant_s & win_s;
            res_valid_q <= done_s;
            if (grant_s) begin
                op_a_q    <= win_s ? a1 : a0;
                op_b_q    <= win_s ? b1 : b0;
                cur_id_q  <= win_s;
                last_id_q <= win_s;
            end else begin
                op_a_q    <= op_a_q;
                op_b_q    <= op_b_q;
                cur_id_q  <= cur_id_q;
                last_id_q <= last_id_q;
            end
            if (state_q == S_INIT) begin
                cnt_q <= '0;
            end else if (step_s) begin
                cnt_q <= cnt_q + CW'(1);
            end else begin
                cnt_q <= cnt_q;
            end
            if (done_s) begin
                res_q    <= dp_s;
                res_id_q <= cur_id_q;
            end else begin
                res_q    <= res_q;
                res_id_q <= res_id_q;
            end
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign dp_a_in   = op_a_q;
    assign dp_b_in   = op_b_q;
    assign res       = res_q;
    assign res_id    = res_id_q;
    assign res_valid = res_valid_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: a behavioural shift-add datapath closes the loop,
// directed vectors check grant, control sequence, latency and product.
module tb_mult_share_ctrl;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           req0 = 1'b0, req1 = 1'b0;
    logic [N-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic           gnt0, gnt1;
    logic [N-1:0]   dp_a_in, dp_b_in;
    logic           init, plus, shift, finish;
    logic [N-1:0]   dp_b;
    logic [2*N-1:0] dp_s;
    logic [2*N-1:0] res;
    logic           res_id, res_valid, busy;

    // Behavioural datapath: A shifts left, B shifts right, S accumulates A.
    logic [2*N-1:0] m_a = '0;
    logic [N-1:0]   m_b = '0;
    logic [2*N-1:0] m_s = '0;

    int n_tests = 0;
    int n_fail  = 0;

    mult_share_ctrl #(.N(N)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .dp_a_in(dp_a_in), .dp_b_in(dp_b_in),
        .init(init), .plus(plus), .shift(shift), .finish(finish),
        .dp_b(dp_b), .dp_s(dp_s),
        .res(res), .res_id(res_id), .res_valid(res_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (init) begin
            m_a <= {{N{1'b0}}, dp_a_in};
            m_b <= dp_b_in;
            m_s <= '0;
        end else if (plus) begin
            m_s <= m_s + m_a;
            m_a <= m_a << 1;
            m_b <= m_b >> 1;
        end else if (shift) begin
            m_a <= m_a << 1;
            m_b <= m_b >> 1;
        end
    end

    assign dp_b = m_b;
    assign dp_s = m_s;

    typedef struct {
        logic           id;
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] exp_res;
        int             lat;
        logic [7:0][2:0] seq;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // 1=init 2=plus 3=shift 4=finish 0=none
    function automatic logic [2:0] ctrl_code();
        if (init)        return 3'd1;
        else if (plus)   return 3'd2;
        else if (shift)  return 3'd3;
        else if (finish) return 3'd4;
        else             return 3'd0;
    endfunction

    task automatic run_op(input logic id, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2*N-1:0] exp_res, input int exp_lat,
                          input logic [7:0][2:0] seq, input bit chk_seq, input string nm);
        int got_lat;
        logic [2*N-1:0] held;
        got_lat = -1;
        @(negedge clk);
        if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
        else    begin req0 = 1'b1; a0 = a; b0 = b; end
        for (int c = 1; c <= N + 6; c++) begin
            @(negedge clk);
            chk({nm, " onehot"}, 32'(init + plus + shift + finish) <= 32'd1 ? 32'd1 : 32'd0, 32'd1);
            if (c == 1) begin
                chk({nm, " gnt_own"}, 32'(id ? gnt1 : gnt0), 32'd1);
                chk({nm, " gnt_other"}, 32'(id ? gnt0 : gnt1), 32'd0);
                chk({nm, " busy"}, 32'(busy), 32'd1);
                req0 = 1'b0;
                req1 = 1'b0;
            end
            if (chk_seq && c < exp_lat)
                chk({nm, " ctrl"}, 32'(ctrl_code()), 32'(seq[c-1]));
            if (res_valid) begin
                got_lat = c;
                break;
            end
        end
        chk({nm, " latency"}, 32'(got_lat), 32'(exp_lat));
        chk({nm, " res"}, 32'(res), 32'(exp_res));
        chk({nm, " res_id"}, 32'(res_id), 32'(id));
        chk({nm, " idle_at_valid"}, 32'(busy), 32'd0);
        held = res;
        @(negedge clk);
        chk({nm, " valid_pulse"}, 32'(res_valid), 32'd0);
        chk({nm, " res_held"}, 32'(res), 32'(held));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " gnt"}, 32'({gnt0, gnt1}), 32'd0);
        chk({nm, " ctrl"}, 32'({init, plus, shift, finish}), 32'd0);
        chk({nm, " res"}, 32'(res), 32'd0);
        chk({nm, " res_id_valid_busy"}, 32'({res_id, res_valid, busy}), 32'd0);
        chk({nm, " operands"}, 32'({dp_a_in, dp_b_in}), 32'd0);
    endtask

    initial begin
        int k;
        int rv_cnt;
        int last_rv;
        bit saw_rv;
        logic [7:0][2:0] noseq;
        logic exp_id;

        noseq = '0;
        vecs[0] = '{1'b0, 4'd13, 4'd11, 8'd143, 7, {3'd0, 3'd0, 3'd4, 3'd2, 3'd3, 3'd2, 3'd2, 3'd1}};
        vecs[1] = '{1'b1, 4'd3,  4'd2,  8'd6,   5, {3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd2, 3'd3, 3'd1}};
        vecs[2] = '{1'b0, 4'd7,  4'd0,  8'd0,   3, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd1}};
        vecs[3] = '{1'b0, 4'd15, 4'd15, 8'd225, 7, {3'd0, 3'd0, 3'd4, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1}};
        vecs[4] = '{1'b1, 4'd9,  4'd8,  8'd72,  7, {3'd0, 3'd0, 3'd4, 3'd2, 3'd3, 3'd3, 3'd3, 3'd1}};
        vecs[5] = '{1'b1, 4'd0,  4'd5,  8'd0,   6, {3'd0, 3'd0, 3'd0, 3'd4, 3'd2, 3'd3, 3'd2, 3'd1}};

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_no_req busy", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].lat,
                   vecs[i].seq, 1'b1, $sformatf("vec%0d", i));

        // Both requesters held high from reset: ids must alternate 0,1,0,1.
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        a0 = 4'd2; b0 = 4'd3; a1 = 4'd5; b1 = 4'd1;
        req0 = 1'b1; req1 = 1'b1;
        rv_cnt = 0;
        last_rv = -1;
        exp_id = 1'b0;
        for (int c = 1; c <= 60 && rv_cnt < 4; c++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                chk("tie gnt_id", 32'(gnt1), 32'(exp_id));
                if (last_rv >= 0) chk("tie gnt_gap", 32'(c), 32'(last_rv + 1));
            end
            if (res_valid) begin
                chk("tie res_id", 32'(res_id), 32'(exp_id));
                chk("tie res", 32'(res), exp_id ? 32'd5 : 32'd6);
                exp_id = ~exp_id;
                last_rv = c;
                rv_cnt++;
                if (rv_cnt == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
        end
        chk("tie result_count", 32'(rv_cnt), 32'd4);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset pulsed mid-operation: outputs clear at once and no result appears.
        a0 = 4'd13; b0 = 4'd11; req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        reset_n = 1'b1;
        saw_rv = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (res_valid || busy) saw_rv = 1'b1;
        end
        chk("abort no_result", 32'(saw_rv), 32'd0);
        run_op(1'b0, 4'd13, 4'd11, 8'd143, 7, vecs[0].seq, 1'b1, "after_abort");

        // Exhaustive operand sweep: product and latency from bit length of b.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                k = 0;
                for (int i = 0; i < N; i++) if (b[i]) k = i + 1;
                run_op(1'(b & 1), 4'(a), 4'(b), 8'(a * b), k + 3, noseq, 1'b0, "sweep");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
